// File: rtl/dcache_miss_ctrl_pkg.sv
// dcache_miss_ctrl_pkg
//   Shared definitions for the D$ miss controller: line and address widths,
//   the memory request record driven onto the miss request port, the
//   controller state encoding and the default watchdog limit.
package dcache_miss_ctrl_pkg;

  localparam int unsigned DCACHE_LINE_WIDTH   = 128;
  localparam int unsigned MEM_ADDR_WIDTH      = 32;
  localparam int unsigned DCACHE_MISS_TIMEOUT = 1024;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0]    addr;
    logic                         is_store;
    logic [DCACHE_LINE_WIDTH-1:0] data;
  } memory_request_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_REQ,
    S_WB_WAIT,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_DONE
  } dcache_miss_state_t;

  function automatic memory_request_t make_req(
    input logic [MEM_ADDR_WIDTH-1:0]    addr,
    input logic                         is_store,
    input logic [DCACHE_LINE_WIDTH-1:0] data
  );
    memory_request_t req;
    req.addr     = addr;
    req.is_store = is_store;
    req.data     = data;
    return req;
  endfunction

endpackage

// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl
//   Requester side of the cache-miss memory protocol for the D$. Takes one
//   line miss at a time, writes back a dirty victim first, then fills the
//   line and reports data or a bus error back to the D$.
//
//   Optional feature: define DCACHE_MISS_TIMEOUT_EN to add a watchdog that
//   ends a wait state with fill_error after TIMEOUT_CYCLES cycles.
//
// Ports
//   clock, reset             core clock, synchronous active-high reset
//   miss_req_valid/addr      one-cycle miss request and line address
//   victim_dirty/addr/data   victim line to write back when dirty
//   miss_busy                controller not idle; D$ stalls new misses
//   fill_valid/addr/data     one-cycle fill result
//   fill_error               bus error or timeout, qualified by fill_valid
//   dcache_req_valid_miss    one-cycle request pulse to memory
//   dcache_req_info_miss     request record {addr, is_store, data}
//   rsp_valid_miss           response valid on the shared bus
//   rsp_cache_id             response owner, 1 = D$
//   rsp_bus_error            response carries a bus error
//   rsp_data_miss            response line data
module dcache_miss_ctrl
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int unsigned LINE_W         = DCACHE_LINE_WIDTH,
  parameter int unsigned ADDR_W         = MEM_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DCACHE_MISS_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              miss_req_valid,
  input  logic [ADDR_W-1:0] miss_req_addr,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic [LINE_W-1:0] victim_data,
  output logic              miss_busy,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_data,
  output logic              fill_error,
  output logic              dcache_req_valid_miss,
  output memory_request_t   dcache_req_info_miss,
  input  logic              rsp_valid_miss,
  input  logic              rsp_cache_id,
  input  logic              rsp_bus_error,
  input  logic [LINE_W-1:0] rsp_data_miss
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("dcache_miss_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  dcache_miss_state_t state;
  logic [ADDR_W-1:0]  miss_addr;
  logic               rsp_hit;
  logic               timeout_hit;

  // Only D$-tagged responses are ours; the bus never carries both at once.
  assign rsp_hit = rsp_valid_miss & rsp_cache_id;

`ifdef DCACHE_MISS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt;

  // Every wait state is entered from a non-wait state, so holding the
  // counter at zero outside the wait states clears it on entry.
  always_ff @(posedge clock) begin
    if (reset || !(state inside {S_WB_WAIT, S_FILL_WAIT})) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: all state and outputs live in one clocked block written with
  // non-blocking assignments, so every output is a flop and each branch
  // reads pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= S_IDLE;
      miss_addr             <= '0;
      miss_busy             <= 1'b0;
      fill_valid            <= 1'b0;
      fill_addr             <= '0;
      fill_data             <= '0;
      fill_error            <= 1'b0;
      dcache_req_valid_miss <= 1'b0;
      dcache_req_info_miss  <= '0;
    end else begin
      // Pulses default low; only the issuing transition raises them.
      dcache_req_valid_miss <= 1'b0;
      fill_valid            <= 1'b0;

      case (state)
        S_IDLE: begin
          if (miss_req_valid) begin
            miss_addr             <= miss_req_addr;
            miss_busy             <= 1'b1;
            dcache_req_valid_miss <= 1'b1;
            // The request record is loaded here so it is already stable in
            // the pulse cycle and the victim need not be stored separately.
            if (victim_dirty) begin
              dcache_req_info_miss <= make_req(victim_addr, 1'b1, victim_data);
              state                <= S_WB_REQ;
            end else begin
              dcache_req_info_miss <= make_req(miss_req_addr, 1'b0, '0);
              state                <= S_FILL_REQ;
            end
          end
        end

        S_WB_REQ: state <= S_WB_WAIT;

        S_WB_WAIT: begin
          if (rsp_hit) begin
            if (rsp_bus_error) begin
              // Skip the fill; fill_data keeps its previous contents.
              fill_valid <= 1'b1;
              fill_addr  <= miss_addr;
              fill_error <= 1'b1;
              state      <= S_DONE;
            end else begin
              dcache_req_valid_miss <= 1'b1;
              dcache_req_info_miss  <= make_req(miss_addr, 1'b0, '0);
              state                 <= S_FILL_REQ;
            end
          end else if (timeout_hit) begin
            fill_valid <= 1'b1;
            fill_addr  <= miss_addr;
            fill_error <= 1'b1;
            state      <= S_DONE;
          end
        end

        S_FILL_REQ: state <= S_FILL_WAIT;

        S_FILL_WAIT: begin
          if (rsp_hit) begin
            fill_valid <= 1'b1;
            fill_addr  <= miss_addr;
            fill_data  <= rsp_data_miss;
            fill_error <= rsp_bus_error;
            state      <= S_DONE;
          end else if (timeout_hit) begin
            fill_valid <= 1'b1;
            fill_addr  <= miss_addr;
            fill_error <= 1'b1;
            state      <= S_DONE;
          end
        end

        S_DONE: begin
          miss_busy <= 1'b0;
          state     <= S_IDLE;
        end

        default: begin
          miss_busy <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb_dcache_miss_ctrl
//   Self-checking bench for dcache_miss_ctrl. Expected requests and fills are
//   queued when stimulus is driven; a monitor pops and compares them whenever
//   the DUT pulses dcache_req_valid_miss or fill_valid. Scenario tasks add
//   latency and ordering checks. Define DCACHE_MISS_TIMEOUT_EN to include the
//   watchdog scenario.
module tb_dcache_miss_ctrl;
  import dcache_miss_ctrl_pkg::*;

  localparam int LINE_W = DCACHE_LINE_WIDTH;
  localparam int ADDR_W = MEM_ADDR_WIDTH;
  localparam int TO_CYC = 16;

  localparam logic [LINE_W-1:0] D1   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [LINE_W-1:0] D2   = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [LINE_W-1:0] D3   = 128'hCAFEF00D_12345678_9ABCDEF0_0BADBEEF;
  localparam logic [LINE_W-1:0] D4   = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
  localparam logic [LINE_W-1:0] JUNK = 128'hDEADDEAD_DEADDEAD_DEADDEAD_DEADDEAD;
  localparam logic [LINE_W-1:0] VA   = {8{16'hAAAA}};
  localparam logic [LINE_W-1:0] V5   = {8{16'h5555}};

  logic              clock;
  logic              reset;
  logic              miss_req_valid;
  logic [ADDR_W-1:0] miss_req_addr;
  logic              victim_dirty;
  logic [ADDR_W-1:0] victim_addr;
  logic [LINE_W-1:0] victim_data;
  logic              miss_busy;
  logic              fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic [LINE_W-1:0] fill_data;
  logic              fill_error;
  logic              dcache_req_valid_miss;
  memory_request_t   dcache_req_info_miss;
  logic              rsp_valid_miss;
  logic              rsp_cache_id;
  logic              rsp_bus_error;
  logic [LINE_W-1:0] rsp_data_miss;

  dcache_miss_ctrl #(
    .LINE_W         (LINE_W),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .miss_req_valid        (miss_req_valid),
    .miss_req_addr         (miss_req_addr),
    .victim_dirty          (victim_dirty),
    .victim_addr           (victim_addr),
    .victim_data           (victim_data),
    .miss_busy             (miss_busy),
    .fill_valid            (fill_valid),
    .fill_addr             (fill_addr),
    .fill_data             (fill_data),
    .fill_error            (fill_error),
    .dcache_req_valid_miss (dcache_req_valid_miss),
    .dcache_req_info_miss  (dcache_req_info_miss),
    .rsp_valid_miss        (rsp_valid_miss),
    .rsp_cache_id          (rsp_cache_id),
    .rsp_bus_error         (rsp_bus_error),
    .rsp_data_miss         (rsp_data_miss)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
    logic              err;
  } fill_exp_t;

  memory_request_t exp_req[$];
  fill_exp_t       exp_fill[$];

  int total = 0;
  int bad   = 0;
  int req_count  = 0;
  int fill_count = 0;
  int req_cyc    = -1;
  int fill_cyc   = -1;

  memory_request_t mon_req;
  fill_exp_t       mon_fill;

  function automatic memory_request_t req_of(input logic [ADDR_W-1:0] a,
                                             input logic st,
                                             input logic [LINE_W-1:0] d);
    memory_request_t r;
    r.addr = a;
    r.is_store = st;
    r.data = d;
    return r;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (dcache_req_valid_miss === 1'b1) begin
      req_count++;
      req_cyc = cyc;
      total++;
      if (exp_req.size() == 0) begin
        bad++;
        $display("FAIL unexpected_req: got addr=%h is_store=%b at cycle %0d, required no request",
                 dcache_req_info_miss.addr, dcache_req_info_miss.is_store, cyc);
      end else begin
        mon_req = exp_req.pop_front();
        if (dcache_req_info_miss !== mon_req) begin
          bad++;
          $display("FAIL req_info: got addr=%h st=%b data=%h, required addr=%h st=%b data=%h",
                   dcache_req_info_miss.addr, dcache_req_info_miss.is_store,
                   dcache_req_info_miss.data, mon_req.addr, mon_req.is_store, mon_req.data);
        end
      end
    end
    if (fill_valid === 1'b1) begin
      fill_count++;
      fill_cyc = cyc;
      total++;
      if (exp_fill.size() == 0) begin
        bad++;
        $display("FAIL unexpected_fill: got addr=%h err=%b at cycle %0d, required no fill",
                 fill_addr, fill_error, cyc);
      end else begin
        mon_fill = exp_fill.pop_front();
        if (fill_addr !== mon_fill.addr || fill_error !== mon_fill.err ||
            (!mon_fill.err && fill_data !== mon_fill.data)) begin
          bad++;
          $display("FAIL fill_result: got addr=%h err=%b data=%h, required addr=%h err=%b data=%h",
                   fill_addr, fill_error, fill_data, mon_fill.addr, mon_fill.err, mon_fill.data);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic issue_miss(input logic [ADDR_W-1:0] a, input logic dirty,
                            input logic [ADDR_W-1:0] va, input logic [LINE_W-1:0] vd);
    miss_req_valid = 1'b1;
    miss_req_addr  = a;
    victim_dirty   = dirty;
    victim_addr    = va;
    victim_data    = vd;
    tick();
    miss_req_valid = 1'b0;
    victim_dirty   = 1'b0;
  endtask

  task automatic respond(input logic id, input logic err, input logic [LINE_W-1:0] d);
    rsp_valid_miss = 1'b1;
    rsp_cache_id   = id;
    rsp_bus_error  = err;
    rsp_data_miss  = d;
    tick();
    rsp_valid_miss = 1'b0;
    rsp_cache_id   = 1'b0;
    rsp_bus_error  = 1'b0;
    rsp_data_miss  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++;
    if ({miss_busy, fill_valid, fill_error, dcache_req_valid_miss} !== 4'b0 ||
        dcache_req_info_miss !== '0 || fill_addr !== '0 || fill_data !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b fv=%b fe=%b rv=%b addr=%h data=%h, required all zero",
               miss_busy, fill_valid, fill_error, dcache_req_valid_miss, fill_addr, fill_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_clean_miss();
    int n, r, br, bf;
    exp_req.push_back(req_of(32'h40, 1'b0, '0));
    exp_fill.push_back('{addr: 32'h40, data: D1, err: 1'b0});
    br = req_count; bf = fill_count; n = cyc;
    issue_miss(32'h40, 1'b0, 32'h0, '0);
    total++;
    if (req_count != br + 1 || req_cyc != n + 1) begin
      bad++;
      $display("FAIL clean_req_latency: got count=%0d cycle=%0d, required count=%0d cycle=%0d",
               req_count - br, req_cyc, 1, n + 1);
    end
    total++;
    if (miss_busy !== 1'b1) begin
      bad++;
      $display("FAIL clean_busy_set: got %b, required 1", miss_busy);
    end
    repeat (4) tick();
    r = cyc;
    respond(1'b1, 1'b0, D1);
    total++;
    if (fill_count != bf + 1 || fill_cyc != r + 1) begin
      bad++;
      $display("FAIL clean_fill_latency: got count=%0d cycle=%0d, required count=1 cycle=%0d",
               fill_count - bf, fill_cyc, r + 1);
    end
    total++;
    if (miss_busy !== 1'b1) begin
      bad++;
      $display("FAIL clean_busy_done: got %b, required 1", miss_busy);
    end
    tick();
    total++;
    if (miss_busy !== 1'b0) begin
      bad++;
      $display("FAIL clean_busy_clear: got %b, required 0", miss_busy);
    end
  endtask

  // Issued in the first IDLE cycle after a DONE.
  task automatic test_back_to_back();
    int n, r, br, bf;
    exp_req.push_back(req_of(32'h44, 1'b0, '0));
    exp_fill.push_back('{addr: 32'h44, data: D2, err: 1'b0});
    br = req_count; bf = fill_count; n = cyc;
    issue_miss(32'h44, 1'b0, 32'h0, '0);
    total++;
    if (req_count != br + 1 || req_cyc != n + 1) begin
      bad++;
      $display("FAIL b2b_req_latency: got count=%0d cycle=%0d, required count=1 cycle=%0d",
               req_count - br, req_cyc, n + 1);
    end
    repeat (2) tick();
    r = cyc;
    respond(1'b1, 1'b0, D2);
    total++;
    if (fill_count != bf + 1 || fill_cyc != r + 1) begin
      bad++;
      $display("FAIL b2b_fill_latency: got count=%0d cycle=%0d, required count=1 cycle=%0d",
               fill_count - bf, fill_cyc, r + 1);
    end
    tick();
  endtask

  task automatic test_dirty_miss();
    int rwb, rf, br, bf;
    exp_req.push_back(req_of(32'h10, 1'b1, VA));
    exp_req.push_back(req_of(32'h80, 1'b0, '0));
    exp_fill.push_back('{addr: 32'h80, data: D3, err: 1'b0});
    br = req_count; bf = fill_count;
    issue_miss(32'h80, 1'b1, 32'h10, VA);
    repeat (2) tick();
    total++;
    if (req_count != br + 1) begin
      bad++;
      $display("FAIL dirty_wb_only: got %0d requests before wb response, required 1", req_count - br);
    end
    rwb = cyc;
    respond(1'b1, 1'b0, JUNK);
    total++;
    if (req_count != br + 2 || req_cyc != rwb + 1) begin
      bad++;
      $display("FAIL dirty_fill_req: got count=%0d cycle=%0d, required count=2 cycle=%0d",
               req_count - br, req_cyc, rwb + 1);
    end
    repeat (2) tick();
    rf = cyc;
    respond(1'b1, 1'b0, D3);
    total++;
    if (fill_count != bf + 1 || fill_cyc != rf + 1) begin
      bad++;
      $display("FAIL dirty_fill_latency: got count=%0d cycle=%0d, required count=1 cycle=%0d",
               fill_count - bf, fill_cyc, rf + 1);
    end
    repeat (3) tick();
    total++;
    if (fill_count != bf + 1) begin
      bad++;
      $display("FAIL dirty_single_fill: got %0d fills, required 1", fill_count - bf);
    end
  endtask

  task automatic test_wb_error();
    int r, br, bf;
    exp_req.push_back(req_of(32'h20, 1'b1, V5));
    exp_fill.push_back('{addr: 32'hC0, data: '0, err: 1'b1});
    br = req_count; bf = fill_count;
    issue_miss(32'hC0, 1'b1, 32'h20, V5);
    repeat (2) tick();
    r = cyc;
    respond(1'b1, 1'b1, JUNK);
    total++;
    if (fill_count != bf + 1 || fill_cyc != r + 1) begin
      bad++;
      $display("FAIL wberr_fill_latency: got count=%0d cycle=%0d, required count=1 cycle=%0d",
               fill_count - bf, fill_cyc, r + 1);
    end
    repeat (4) tick();
    total++;
    if (req_count != br + 1) begin
      bad++;
      $display("FAIL wberr_no_load: got %0d requests, required 1", req_count - br);
    end
  endtask

  task automatic test_foreign_rsp();
    int r, br, bf;
    exp_req.push_back(req_of(32'h100, 1'b0, '0));
    exp_fill.push_back('{addr: 32'h100, data: D4, err: 1'b0});
    br = req_count; bf = fill_count;
    issue_miss(32'h100, 1'b0, 32'h0, '0);
    tick();
    // A miss while busy must be ignored.
    issue_miss(32'h200, 1'b1, 32'h300, VA);
    respond(1'b0, 1'b1, JUNK);
    repeat (2) tick();
    total++;
    if (fill_count != bf || req_count != br + 1) begin
      bad++;
      $display("FAIL foreign_ignored: got fills=%0d reqs=%0d, required fills=0 reqs=1",
               fill_count - bf, req_count - br);
    end
    r = cyc;
    respond(1'b1, 1'b0, D4);
    total++;
    if (fill_count != bf + 1 || fill_cyc != r + 1) begin
      bad++;
      $display("FAIL foreign_fill_latency: got count=%0d cycle=%0d, required count=1 cycle=%0d",
               fill_count - bf, fill_cyc, r + 1);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int r, br, bf;
    exp_req.push_back(req_of(32'h140, 1'b0, '0));
    br = req_count; bf = fill_count;
    issue_miss(32'h140, 1'b0, 32'h0, '0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({miss_busy, fill_valid, fill_error, dcache_req_valid_miss} !== 4'b0 ||
        dcache_req_info_miss !== '0 || fill_addr !== '0 || fill_data !== '0) begin
      bad++;
      $display("FAIL abort_reset_state: got busy=%b fv=%b fe=%b rv=%b addr=%h, required all zero",
               miss_busy, fill_valid, fill_error, dcache_req_valid_miss, fill_addr);
    end
    repeat (2) tick();
    respond(1'b1, 1'b0, JUNK);
    repeat (3) tick();
    total++;
    if (fill_count != bf || req_count != br + 1 || miss_busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_late_rsp: got fills=%0d reqs=%0d busy=%b, required 0 1 0",
               fill_count - bf, req_count - br, miss_busy);
    end
    exp_req.push_back(req_of(32'h180, 1'b0, '0));
    exp_fill.push_back('{addr: 32'h180, data: D1, err: 1'b0});
    issue_miss(32'h180, 1'b0, 32'h0, '0);
    repeat (2) tick();
    r = cyc;
    respond(1'b1, 1'b0, D1);
    total++;
    if (fill_count != bf + 1 || fill_cyc != r + 1) begin
      bad++;
      $display("FAIL abort_recover: got count=%0d cycle=%0d, required count=1 cycle=%0d",
               fill_count - bf, fill_cyc, r + 1);
    end
    tick();
  endtask

`ifdef DCACHE_MISS_TIMEOUT_EN
  task automatic test_timeout();
    int p, bf, n;
    exp_req.push_back(req_of(32'h1C0, 1'b0, '0));
    exp_fill.push_back('{addr: 32'h1C0, data: '0, err: 1'b1});
    bf = fill_count;
    issue_miss(32'h1C0, 1'b0, 32'h0, '0);
    p = req_cyc;
    n = 0;
    while (fill_count == bf && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (fill_count != bf + 1 || fill_cyc != p + TO_CYC + 1) begin
      bad++;
      $display("FAIL timeout_fill: got count=%0d offset=%0d, required count=1 offset=%0d",
               fill_count - bf, fill_cyc - p, TO_CYC + 1);
    end
    repeat (2) tick();
  endtask
`endif

  task automatic test_drain();
    total++;
    if (exp_req.size() != 0 || exp_fill.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d requests and %0d fills outstanding, required 0 and 0",
               exp_req.size(), exp_fill.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    miss_req_valid = 1'b0;
    miss_req_addr  = '0;
    victim_dirty   = 1'b0;
    victim_addr    = '0;
    victim_data    = '0;
    rsp_valid_miss = 1'b0;
    rsp_cache_id   = 1'b0;
    rsp_bus_error  = 1'b0;
    rsp_data_miss  = '0;

    test_reset();
    test_clean_miss();
    test_back_to_back();
    test_dirty_miss();
    test_wb_error();
    test_foreign_rsp();
    test_reset_abort();
`ifdef DCACHE_MISS_TIMEOUT_EN
    test_timeout();
`endif
    test_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
